// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit for the 5-stage MIPS pipeline.
// A direct-mapped BTB with 2-bit saturating counters predicts in IF.
// Control instructions resolve in ID, and only mispredictions redirect the PC and flush IF/ID.
// Saturating counters track resolved control instructions and mispredictions.
module branch_predict_unit #(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // IF-stage lookup
   input  logic [PC_W-1:0]   if_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   // ID-stage resolution
   input  logic              id_valid,
   input  logic              id_stall,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [5:0]        id_op,
   input  logic [5:0]        id_funct,
   input  logic [DATA_W-1:0] data_1,
   input  logic [DATA_W-1:0] data_2,
   input  logic [PC_W-1:0]   id_branch_target,
   input  logic [PC_W-1:0]   id_jump_target,
   input  logic              id_pred_taken,
   input  logic [PC_W-1:0]   id_pred_target,
   output logic [1:0]        pc_sel,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              IFID_flush,
   // statistics
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int TAG_W = PC_W - IDX_W - 2;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] FN_JR      = 6'b001000;

   localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
   localparam logic [1:0] PC_SEL_PRED = 2'b01;
   localparam logic [1:0] PC_SEL_REDIR = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [1:0]       ctr;
   } btb_entry_t;

   // Invalid, weakly not-taken.
   localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

   btb_entry_t       btb_q [BHT_DEPTH];
   btb_entry_t       upd_entry_d;
   logic             upd_en;
   logic [CNT_W-1:0] br_q, br_d;
   logic [CNT_W-1:0] mis_q, mis_d;

   // ---------------------------------------------------------------- IF lookup
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   btb_entry_t       if_entry;

   assign if_idx   = if_pc[IDX_W+1:2];
   assign if_tag   = if_pc[PC_W-1:IDX_W+2];
   assign if_entry = btb_q[if_idx];

   assign pred_taken  = if_entry.valid && (if_entry.tag == if_tag) && if_entry.ctr[1];
   assign pred_target = pred_taken ? if_entry.target : '0;

   // The low PC bits never reach the table because instructions are word aligned.
   logic unused_if_pc_bits;
   assign unused_if_pc_bits = ^if_pc[1:0];

   // ------------------------------------------------------------ ID resolution
   logic            is_ctrl, is_cond, act_taken, resolve, mispredict;
   logic [PC_W-1:0] act_target;

   // Decode the control instruction and compute its actual outcome.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and infers a latch.
      is_ctrl    = 1'b0;
      is_cond    = 1'b0;
      act_taken  = 1'b0;
      act_target = '0;
      unique case (id_op)
         OP_BEQ: begin
            is_ctrl = 1'b1; is_cond = 1'b1;
            act_taken = (data_1 == data_2); act_target = id_branch_target;
         end
         OP_BNE: begin
            is_ctrl = 1'b1; is_cond = 1'b1;
            act_taken = (data_1 != data_2); act_target = id_branch_target;
         end
         OP_BLEZ: begin
            is_ctrl = 1'b1; is_cond = 1'b1;
            act_taken = ($signed(data_1) <= 0); act_target = id_branch_target;
         end
         OP_BGTZ: begin
            is_ctrl = 1'b1; is_cond = 1'b1;
            act_taken = ($signed(data_1) > 0); act_target = id_branch_target;
         end
         OP_J, OP_JAL: begin
            is_ctrl = 1'b1; act_taken = 1'b1; act_target = id_jump_target;
         end
         OP_SPECIAL: begin
            if (id_funct == FN_JR) begin
               is_ctrl = 1'b1; act_taken = 1'b1; act_target = data_1[PC_W-1:0];
            end
         end
         default: ;
      endcase
   end

   assign resolve    = id_valid && !id_stall && is_ctrl;
   assign mispredict = resolve &&
                       ((act_taken != id_pred_taken) ||
                        (act_taken && id_pred_taken && (act_target != id_pred_target)));

   // Next-PC selection: an ID redirect always overrides the IF prediction.
   always_comb begin
      pc_sel      = pred_taken ? PC_SEL_PRED : PC_SEL_SEQ;
      redirect_pc = '0;
      IFID_flush  = 1'b0;
      if (mispredict) begin
         pc_sel      = PC_SEL_REDIR;
         IFID_flush  = 1'b1;
         redirect_pc = act_taken ? act_target : id_pc + PC_W'(4);
      end
   end

   // ------------------------------------------------------------ table update
   logic [IDX_W-1:0] id_idx;
   logic [TAG_W-1:0] id_tag;
   btb_entry_t       id_entry;
   logic             id_hit;

   assign id_idx   = id_pc[IDX_W+1:2];
   assign id_tag   = id_pc[PC_W-1:IDX_W+2];
   assign id_entry = btb_q[id_idx];
   assign id_hit   = id_entry.valid && (id_entry.tag == id_tag);

   // Build the new entry for the ID instruction's index from its outcome.
   always_comb begin
      upd_en      = 1'b0;
      upd_entry_d = id_entry;
      if (resolve) begin
         if (!is_cond) begin
            upd_en      = 1'b1;
            upd_entry_d = '{valid: 1'b1, tag: id_tag, target: act_target, ctr: 2'b11};
         end else if (id_hit) begin
            upd_en = 1'b1;
            if (act_taken) begin
               upd_entry_d.target = act_target;
               if (id_entry.ctr != 2'b11) upd_entry_d.ctr = id_entry.ctr + 2'b01;
            end else if (id_entry.ctr != 2'b00) begin
               upd_entry_d.ctr = id_entry.ctr - 2'b01;
            end
         end else if (act_taken) begin
            upd_en      = 1'b1;
            upd_entry_d = '{valid: 1'b1, tag: id_tag, target: act_target, ctr: 2'b10};
         end
      end
   end

   // BTB storage; a same-cycle lookup sees the entry as it was before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the table is reset entry by entry because an unreset BTB could predict garbage targets after reset.
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) btb_q[i] <= RESET_ENTRY;
      end else if (upd_en) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         btb_q[id_idx] <= upd_entry_d;
      end
   end

   // ------------------------------------------------------------ statistics
   // Saturating increments: hold at all-ones instead of wrapping.
   always_comb begin
      br_d  = br_q;
      mis_d = mis_q;
      if (resolve && (br_q != '1))     br_d  = br_q + CNT_W'(1);
      if (mispredict && (mis_q != '1)) mis_d = mis_q + CNT_W'(1);
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q  <= '0;
         mis_q <= '0;
      end else begin
         br_q  <= br_d;
         mis_q <= mis_d;
      end
   end

   assign stat_branches    = br_q;
   assign stat_mispredicts = mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a table-level model checked every cycle plus directed literal checks.
module tb_branch_predict_unit;

   localparam int PC_W      = 32;
   localparam int DATA_W    = 32;
   localparam int BHT_DEPTH = 16;
   localparam int CNT_W     = 4;   // small, so the statistics saturate within a short run
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [PC_W-1:0]   if_pc;
   logic              pred_taken;
   logic [PC_W-1:0]   pred_target;
   logic              id_valid, id_stall;
   logic [PC_W-1:0]   id_pc;
   logic [5:0]        id_op, id_funct;
   logic [DATA_W-1:0] data_1, data_2;
   logic [PC_W-1:0]   id_branch_target, id_jump_target;
   logic              id_pred_taken;
   logic [PC_W-1:0]   id_pred_target;
   logic [1:0]        pc_sel;
   logic [PC_W-1:0]   redirect_pc;
   logic              IFID_flush;
   logic [CNT_W-1:0]  stat_branches, stat_mispredicts;

   int total = 0;
   int bad   = 0;

   branch_predict_unit #(
      .PC_W(PC_W), .DATA_W(DATA_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
      .id_op(id_op), .id_funct(id_funct), .data_1(data_1), .data_2(data_2),
      .id_branch_target(id_branch_target), .id_jump_target(id_jump_target),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
      .pc_sel(pc_sel), .redirect_pc(redirect_pc), .IFID_flush(IFID_flush),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit          m_val [BHT_DEPTH];
   logic [31:0] m_tag [BHT_DEPTH];
   logic [31:0] m_tgt [BHT_DEPTH];
   int          m_ctr [BHT_DEPTH];
   int          m_br, m_mis;

   bit          p_res = 0, p_mis, p_cond, p_taken;
   logic [31:0] p_tgt, p_pc;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % BHT_DEPTH);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> ($clog2(BHT_DEPTH) + 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT_DEPTH; i++) begin
         m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_br = 0; m_mis = 0; p_res = 0;
   endtask

   // Evaluate the rules on the current inputs, compare, and remember what the next edge must do.
   initial forever begin
      int          i;
      bit          e_pt, ctrl, cond, taken, res, mis;
      logic [31:0] e_ptg, tgt;
      @(negedge clk);
      if (!rst_n) model_reset();
      i     = slot(if_pc);
      e_pt  = m_val[i] && (m_tag[i] == tag_of(if_pc)) && (m_ctr[i] >= 2);
      e_ptg = e_pt ? m_tgt[i] : 32'h0;
      ctrl = 0; cond = 0; taken = 0; tgt = 0;
      case (id_op)
         6'd4: begin ctrl = 1; cond = 1; taken = (data_1 == data_2);     tgt = id_branch_target; end
         6'd5: begin ctrl = 1; cond = 1; taken = (data_1 != data_2);     tgt = id_branch_target; end
         6'd6: begin ctrl = 1; cond = 1; taken = ($signed(data_1) <= 0); tgt = id_branch_target; end
         6'd7: begin ctrl = 1; cond = 1; taken = ($signed(data_1) > 0);  tgt = id_branch_target; end
         6'd2, 6'd3: begin ctrl = 1; taken = 1; tgt = id_jump_target; end
         6'd0: if (id_funct == 6'd8) begin ctrl = 1; taken = 1; tgt = data_1; end
         default: ;
      endcase
      res = id_valid && !id_stall && ctrl;
      mis = res && ((taken != id_pred_taken) || (taken && tgt != id_pred_target));
      check("m_pred_taken",  32'(pred_taken), 32'(e_pt));
      check("m_pred_target", pred_target, e_ptg);
      check("m_pc_sel",      32'(pc_sel), mis ? 32'd2 : (e_pt ? 32'd1 : 32'd0));
      check("m_redirect_pc", redirect_pc, mis ? (taken ? tgt : id_pc + 32'd4) : 32'h0);
      check("m_flush",       32'(IFID_flush), 32'(mis));
      check("m_stat_br",     32'(stat_branches), 32'(m_br));
      check("m_stat_mis",    32'(stat_mispredicts), 32'(m_mis));
      p_res = res; p_mis = mis; p_cond = cond; p_taken = taken; p_tgt = tgt; p_pc = id_pc;
   end

   // Apply the remembered update at the clock edge.
   always @(posedge clk) begin
      int j;
      bit hit;
      if (rst_n && p_res) begin
         j   = slot(p_pc);
         hit = m_val[j] && (m_tag[j] == tag_of(p_pc));
         if (m_br < CNT_MAX) m_br++;
         if (p_mis && m_mis < CNT_MAX) m_mis++;
         if (!p_cond) begin
            m_val[j] = 1; m_tag[j] = tag_of(p_pc); m_tgt[j] = p_tgt; m_ctr[j] = 3;
         end else if (hit) begin
            if (p_taken) begin
               m_tgt[j] = p_tgt;
               if (m_ctr[j] < 3) m_ctr[j]++;
            end else if (m_ctr[j] > 0) begin
               m_ctr[j]--;
            end
         end else if (p_taken) begin
            m_val[j] = 1; m_tag[j] = tag_of(p_pc); m_tgt[j] = p_tgt; m_ctr[j] = 2;
         end
         p_res = 0;
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic drive(input bit v, input bit st, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] bt, input logic [31:0] jt,
                        input bit pt, input logic [31:0] ptg, input logic [31:0] ifpc);
      @(posedge clk); #1;
      id_valid = v; id_stall = st; id_op = op; id_funct = fn; id_pc = pc;
      data_1 = d1; data_2 = d2; id_branch_target = bt; id_jump_target = jt;
      id_pred_taken = pt; id_pred_target = ptg; if_pc = ifpc;
   endtask

   task automatic idle(input logic [31:0] ifpc);
      drive(0, 0, 6'h23, 0, 0, 0, 0, 0, 0, 0, 0, ifpc);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   initial begin
      rst_n = 0;
      id_valid = 0; id_stall = 0; id_op = 0; id_funct = 0; id_pc = 0;
      data_1 = 0; data_2 = 0; id_branch_target = 0; id_jump_target = 0;
      id_pred_taken = 0; id_pred_target = 0; if_pc = 32'h40;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // Reset state.
      idle(32'h40); settle();
      check("rst_pred_taken", 32'(pred_taken), 0);
      check("rst_pred_target", pred_target, 0);
      check("rst_pc_sel", 32'(pc_sel), 0);
      check("rst_flush", 32'(IFID_flush), 0);
      check("rst_stats", 32'({stat_branches, stat_mispredicts}), 0);

      // Cold beq taken; the same-cycle lookup of 0x40 still sees the empty entry.
      drive(1, 0, 6'd4, 0, 32'h40, 5, 5, 32'h80, 0, 0, 0, 32'h40); settle();
      check("beq_cold_pc_sel", 32'(pc_sel), 2);
      check("beq_cold_redirect", redirect_pc, 32'h80);
      check("beq_cold_flush", 32'(IFID_flush), 1);
      check("beq_cold_same_cycle_pred", 32'(pred_taken), 0);
      idle(32'h40); settle();
      check("beq_alloc_pred", 32'(pred_taken), 1);
      check("beq_alloc_target", pred_target, 32'h80);
      check("beq_alloc_pc_sel", 32'(pc_sel), 1);
      check("beq_alloc_br", 32'(stat_branches), 1);
      check("beq_alloc_mis", 32'(stat_mispredicts), 1);

      // Three correctly predicted taken, then one not-taken mispredict.
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 6'd4, 0, 32'h40, 5, 5, 32'h80, 0, 1, 32'h80, 32'h200); settle();
         check("beq_ok_pc_sel", 32'(pc_sel), 0);
         check("beq_ok_flush", 32'(IFID_flush), 0);
      end
      drive(1, 0, 6'd4, 0, 32'h40, 5, 6, 32'h80, 0, 1, 32'h80, 32'h200); settle();
      check("beq_nt_redirect", redirect_pc, 32'h44);
      check("beq_nt_flush", 32'(IFID_flush), 1);
      idle(32'h40); settle();
      check("beq_ctr10_pred", 32'(pred_taken), 1);
      check("beq_nt_br", 32'(stat_branches), 5);
      check("beq_nt_mis", 32'(stat_mispredicts), 2);

      // jr with wrong predicted target; overwrites index 0.
      drive(1, 0, 6'd0, 6'd8, 32'h100, 32'h2000, 0, 0, 0, 1, 32'h1FFC, 32'h200); settle();
      check("jr_pc_sel", 32'(pc_sel), 2);
      check("jr_redirect", redirect_pc, 32'h2000);
      idle(32'h100); settle();
      check("jr_pred", 32'(pred_taken), 1);
      check("jr_pred_target", pred_target, 32'h2000);

      // Stalled bne does nothing; released it redirects.
      drive(1, 1, 6'd5, 0, 32'h44, 1, 2, 32'h90, 0, 0, 0, 32'h200); settle();
      check("bne_stall_pc_sel", 32'(pc_sel), 0);
      check("bne_stall_flush", 32'(IFID_flush), 0);
      check("bne_stall_br", 32'(stat_branches), 6);
      drive(1, 0, 6'd5, 0, 32'h44, 1, 2, 32'h90, 0, 0, 0, 32'h200); settle();
      check("bne_go_pc_sel", 32'(pc_sel), 2);
      check("bne_go_redirect", redirect_pc, 32'h90);
      idle(32'h200); settle();
      check("bne_br", 32'(stat_branches), 7);
      check("bne_mis", 32'(stat_mispredicts), 4);

      // Aliasing: 0x40 and 0x80 share index 0 with different tags.
      drive(1, 0, 6'd4, 0, 32'h40, 7, 7, 32'h80, 0, 0, 0, 32'h200);
      idle(32'h80); settle();
      check("alias_pred", 32'(pred_taken), 0);
      idle(32'h40); settle();
      check("alias_owner_pred", 32'(pred_taken), 1);

      // Signed-compare boundaries, a non-control op, and a correctly predicted j.
      drive(1, 0, 6'd7, 0, 32'h300, 0, 0, 32'h500, 0, 0, 0, 32'h200); settle();
      check("bgtz_zero_flush", 32'(IFID_flush), 0);
      drive(1, 0, 6'd6, 0, 32'h304, 0, 0, 32'h600, 0, 0, 0, 32'h200); settle();
      check("blez_zero_redirect", redirect_pc, 32'h600);
      drive(1, 0, 6'd6, 0, 32'h308, 32'h8000_0000, 0, 32'h700, 0, 1, 32'h700, 32'h200); settle();
      check("blez_neg_flush", 32'(IFID_flush), 0);
      drive(1, 0, 6'd7, 0, 32'h30C, 32'hFFFF_FFFF, 0, 32'h800, 0, 0, 0, 32'h200); settle();
      check("bgtz_neg_flush", 32'(IFID_flush), 0);
      drive(1, 0, 6'h23, 0, 32'h310, 0, 0, 0, 32'h900, 1, 32'h900, 32'h200); settle();
      check("nonctrl_flush", 32'(IFID_flush), 0);
      drive(1, 0, 6'd2, 0, 32'h314, 0, 0, 0, 32'hA00, 1, 32'hA00, 32'h200); settle();
      check("j_ok_flush", 32'(IFID_flush), 0);
      drive(1, 0, 6'd3, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hB00, 0, 0, 32'h200);
      idle(32'h200); settle();
      check("mid_br", 32'(stat_branches), 14);
      check("mid_mis", 32'(stat_mispredicts), 7);

      // Saturation of both statistics.
      for (int k = 0; k < 10; k++)
         drive(1, 0, 6'd2, 0, 32'h400 + 32'(4 * k), 0, 0, 0, 32'hC00, 0, 0, 32'h200);
      idle(32'h200); settle();
      check("sat_br", 32'(stat_branches), CNT_MAX);
      check("sat_mis", 32'(stat_mispredicts), CNT_MAX);

      // Mid-run asynchronous reset clears predictions and stats immediately.
      idle(32'h40);
      #1 rst_n = 0;
      #1;
      check("arst_pred", 32'(pred_taken), 0);
      check("arst_target", pred_target, 0);
      check("arst_stats", 32'({stat_branches, stat_mispredicts}), 0);
      @(posedge clk); #1 rst_n = 1;
      idle(32'h40); settle();
      check("post_rst_pred", 32'(pred_taken), 0);

      idle(32'h0);
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the 5-stage MIPS pipeline. It supersedes the combinational ID-stage branch resolver. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts in IF. Branches and jumps resolve in ID, and only mispredictions redirect the PC and flush IF/ID. The unit covers beq/bne/blez/bgtz/j/jal/jr and keeps saturating prediction statistics.

## Interface
- PC_W, 32, PC width in bits
- DATA_W, 32, register operand width
- BHT_DEPTH, 16, BTB entries; power of two, ≥ 2; IDX_W = log2(BHT_DEPTH)
- CNT_W, 16, statistics counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_W  PC of the instruction being fetched
- pred_taken  out  1  IF prediction: taken
- pred_target  out  PC_W  IF predicted target; 0 when pred_taken=0
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_stall  in  1  ID is stalled this cycle (hazard unit)
- id_pc  in  PC_W  PC of the ID instruction
- id_op  in  6  opcode
- id_funct  in  6  funct field (jr detection)
- data_1, data_2  in  DATA_W  forwarded rs/rt values
- id_branch_target  in  PC_W  computed PC+4+(imm<<2)
- id_jump_target  in  PC_W  computed j/jal target
- id_pred_taken  in  1  pred_taken carried through IF/ID
- id_pred_target  in  PC_W  pred_target carried through IF/ID
- pc_sel  out  2  00 PC+4, 01 pred_target, 10 redirect_pc
- redirect_pc  out  PC_W  corrected next PC
- IFID_flush  out  1  flush IF/ID register
- stat_branches  out  CNT_W  resolved control instructions
- stat_mispredicts  out  CNT_W  resolved mispredictions

## Operation
- Entry state: valid bit, tag (PC_W−IDX_W−2 bits), target (PC_W), 2-bit counter. Index = pc[IDX_W+1:2], tag = pc[PC_W−1:IDX_W+2].
- IF lookup is combinational: pred_taken = valid && tag match && ctr[1]; pred_target = entry target when pred_taken, else 0.
- Resolution happens when id_valid && !id_stall:
  - beq (000100): taken if data_1 == data_2.
  - bne (000101): taken if data_1 != data_2.
  - blez (000110): taken if data_1 ≤ 0, signed.
  - bgtz (000111): taken if data_1 > 0, signed.
  - Target for the four conditional branches is id_branch_target.
  - j (000010) and jal (000011): always taken, target id_jump_target.
  - jr (op 000000, funct 001000): always taken, target data_1[PC_W−1:0].
  - Any other op is not a control instruction. It causes no redirect, no update and no stats change.
- Mispredict when actual_taken != id_pred_taken, or when both are taken and actual target != id_pred_target.
- On mispredict: pc_sel=10, IFID_flush=1, redirect_pc = actual target if taken, else id_pc+4.
- With no mispredict: pc_sel=01 if pred_taken, else 00. IFID_flush=0. redirect_pc=0.
- The ID redirect always overrides the IF prediction in the same cycle.
- When id_stall=1 or id_valid=0: no resolution, no redirect, no table or stats update.
- Update on a resolved control instruction, at the next clock edge:
  - Conditional branch, entry hit (valid and tag match): taken → ctr+1 saturating at 11; not taken → ctr−1 saturating at 00. Target is written if taken.
  - Conditional branch, entry miss: if taken, allocate with valid=1, new tag, target, ctr=10. If not taken, the table is unchanged.
  - Jumps: allocate or overwrite the entry with ctr=11 and the actual target.
- Statistics: stat_branches increments by 1 per resolved control instruction. stat_mispredicts increments by 1 per mispredict. Both saturate at all-ones and never wrap.

## Timing
- Lookup and resolution outputs are combinational, with zero-cycle latency.
- Table and stats updates are registered and visible from the cycle after the edge.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update entry.
- Reset (asynchronous, at any time including mid-update):
  - all valid bits 0
  - all counters 01 (weakly not-taken)
  - tags and targets 0
  - both stats 0
- Consequence of reset: pred_taken=0 and pred_target=0 until an allocation. pc_sel and IFID_flush follow the ID inputs.
- Address arithmetic id_pc+4 wraps modulo 2^PC_W.

## Test plan
- Reset, then if_pc=0x40, id_valid=0 → pred_taken=0, pred_target=0, pc_sel=00, IFID_flush=0, stats=0.
- Cold beq at id_pc=0x40, data_1=data_2=5, target 0x80, id_pred_taken=0 → pc_sel=10, redirect_pc=0x80, IFID_flush=1. Next cycle if_pc=0x40 → pred_taken=1, pred_target=0x80. stat_branches=1, stat_mispredicts=1.
- Same beq resolved taken 3 more times with correct prediction → no flush, pc_sel=00. Then one not-taken with id_pred_taken=1 → redirect_pc=0x44, flush. if_pc=0x40 still predicts taken (ctr 10).
- jr at 0x100 with data_1=0x2000, id_pred_taken=1, id_pred_target=0x1FFC → mispredict, redirect_pc=0x2000. Next lookup of 0x100 → pred_target=0x2000.
- Mispredicting bne presented with id_stall=1 → pc_sel=00, IFID_flush=0, no stats change. Same inputs with id_stall=0 next cycle → redirect.
- BHT_DEPTH=16: entry allocated at 0x40, then if_pc=0x80 (same index, different tag) → pred_taken=0. Mid-run rst_n low → all predictions 0 and stats 0 immediately.
